// File: rtl/alu_issue_control_if.sv
// Issue, ALU and debug signal bundle for alu_issue_control.
// The opCount signal exists only when ALU_ISSUE_OPCOUNT_EN is defined.
interface alu_issue_control_if #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4
);
    logic             instrValid;
    logic             instrReady;
    logic [15:0]      instrWord;
    logic [ALUOP-1:0] aluFunction;
    logic [BITS-1:0]  vectorA;
    logic [BITS-1:0]  vectorB;
    logic             inputCarry;
    logic [BITS-1:0]  aluResult;
    logic             zero;
    logic             overflow;
    logic             outputCarry;
    logic             doneValid;
    logic [BITS-1:0]  doneResult;
    logic [3:0]       statusFlags;
    logic [2:0]       dbgAddr;
    logic [BITS-1:0]  dbgData;
`ifdef ALU_ISSUE_OPCOUNT_EN
    logic [15:0]      opCount;
`endif

    modport slave (
        input  instrValid, instrWord, aluResult, zero, overflow, outputCarry, dbgAddr,
        output instrReady, aluFunction, vectorA, vectorB, inputCarry,
               doneValid, doneResult, statusFlags, dbgData
`ifdef ALU_ISSUE_OPCOUNT_EN
        , output opCount
`endif
    );

    modport master (
        output instrValid, instrWord, aluResult, zero, overflow, outputCarry, dbgAddr,
        input  instrReady, aluFunction, vectorA, vectorB, inputCarry,
               doneValid, doneResult, statusFlags, dbgData
`ifdef ALU_ISSUE_OPCOUNT_EN
        , input opCount
`endif
    );
endinterface

// File: rtl/alu_issue_control.sv
// Issue controller for the combinational ALU: accepts operation words, owns the register file and flags.
// Optional retired-operation counter (opCount) enabled by ALU_ISSUE_OPCOUNT_EN.
//
// state | meaning
// IDLE  | ready for an operation word; operands sampled at the accept edge
// EXEC  | operands presented to the ALU; writeback and flags at the closing edge
// DONE  | one-cycle retire pulse; ALU outputs parked at 0
module alu_issue_control #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4,
    parameter int REGS  = 8
) (
    input logic clock,
    input logic reset,
    alu_issue_control_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [ALUOP-1:0] opReg;
    logic [2:0]       rdReg;
    logic [BITS-1:0]  opA;
    logic [BITS-1:0]  opB;
    logic [BITS-1:0]  regFile [REGS];
    logic             illegalFlag;
    logic             carryFlag;
    logic             overflowFlag;
    logic             zeroFlag;
    logic [BITS-1:0]  doneResultReg;

    logic [ALUOP-1:0] wordOp;
    logic [2:0]       wordRd;
    logic [2:0]       wordRsA;
    logic [2:0]       wordRsB;
    logic             wordUseImm;
    logic [4:0]       wordImm;
    logic             accept;
    logic             execActive;
    logic             legalOp;

    assign wordOp     = bus.instrWord[15:12];
    assign wordRd     = bus.instrWord[11:9];
    assign wordRsA    = bus.instrWord[8:6];
    assign wordUseImm = bus.instrWord[5];
    assign wordImm    = bus.instrWord[4:0];
    assign wordRsB    = bus.instrWord[2:0];

    assign accept     = (state == IDLE) && bus.instrValid;
    assign execActive = (state == EXEC);
    assign legalOp    = (opReg != '0) && (opReg <= ALUOP'(11));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            opReg         <= '0;
            rdReg         <= '0;
            opA           <= '0;
            opB           <= '0;
            illegalFlag   <= 1'b0;
            carryFlag     <= 1'b0;
            overflowFlag  <= 1'b0;
            zeroFlag      <= 1'b0;
            doneResultReg <= '0;
            for (int i = 0; i < REGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg <= wordOp;
                        rdReg <= wordRd;
                        opA   <= regFile[wordRsA];
                        opB   <= wordUseImm ? BITS'(wordImm) : regFile[wordRsB];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (legalOp) begin
                        // r0 stays hard zero; the retire value still reports the ALU result
                        if (rdReg != 3'd0) begin
                            regFile[rdReg] <= bus.aluResult;
                        end
                        doneResultReg <= bus.aluResult;
                        zeroFlag      <= bus.zero;
                        overflowFlag  <= bus.overflow;
                        if (opReg == ALUOP'(1)) begin
                            carryFlag <= bus.outputCarry;
                        end
                    end else begin
                        illegalFlag   <= 1'b1;
                        doneResultReg <= '0;
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_OPCOUNT_EN
    logic [15:0] opCountReg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opCountReg <= '0;
        end else if (execActive) begin
            opCountReg <= opCountReg + 16'd1;
        end
    end

    assign bus.opCount = opCountReg;
`endif

    assign bus.instrReady  = (state == IDLE);
    assign bus.doneValid   = (state == DONE);
    assign bus.doneResult  = doneResultReg;
    assign bus.statusFlags = {illegalFlag, carryFlag, overflowFlag, zeroFlag};
    assign bus.aluFunction = execActive ? opReg : '0;
    assign bus.vectorA     = execActive ? opA : '0;
    assign bus.vectorB     = execActive ? opB : '0;
    assign bus.inputCarry  = execActive & carryFlag;
    assign bus.dbgData     = regFile[bus.dbgAddr];
endmodule

// File: doc/alu_issue_control.md
Name: alu_issue_control

Overview:
Sequential initiator that drives the combinational 8-bit ALU. It accepts 16-bit operation words over a valid/ready handshake and reads operands from an internal 8-entry register file. It presents the operands and function code to the ALU, then writes the result and flags back. It sits between instruction fetch and the ALU, and closes the loop on the ALU's carry, zero and overflow outputs.

Parameters:
BITS, 8, datapath width; matches the ALU operand width.
ALUOP, 4, width of the function code; matches the ALU.
REGS, 8, register-file depth; fixed 3-bit register fields.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
instrValid  input  1  operation word valid
instrReady  output  1  block can accept a word
instrWord  input  16  [15:12] op, [11:9] rd, [8:6] rsA, [5] useImm, [4:0] rsB (low 3 bits) or imm5
aluFunction  output  ALUOP  function code to the ALU
vectorA  output  BITS  operand A to the ALU
vectorB  output  BITS  operand B to the ALU
inputCarry  output  1  stored carry flag to the ALU
aluResult  input  BITS  result from the ALU
zero  input  1  ALU zero flag
overflow  input  1  ALU overflow flag
outputCarry  input  1  ALU carry flag
doneValid  output  1  one-cycle pulse: operation retired
doneResult  output  BITS  value written for the retired operation
statusFlags  output  4  {illegal, carry, overflow, zero}, registered
dbgAddr  input  3  debug read address
dbgData  output  BITS  combinational register-file read at dbgAddr

Behaviour:
- Reset values: state IDLE; regfile all 0; statusFlags 0; doneValid 0; doneResult 0; aluFunction, vectorA, vectorB and inputCarry 0; instrReady 1 after reset deasserts.
- FSM states:
  - IDLE: instrReady = 1. On instrValid && instrReady, latch the op and rd. Latch opA = reg[rsA]. Latch opB = useImm ? zero-extended imm5 : reg[rsB[2:0]]. Go to EXEC.
  - EXEC: drive aluFunction = op, vectorA = opA, vectorB = opB, inputCarry = carry flag. At the closing edge:
    - Legal op (1..11): write aluResult to rd unless rd = 0. Capture doneResult = aluResult. Update zero and overflow from the ALU flags.
    - Update carry from outputCarry only when op = 1; otherwise carry holds.
    - Illegal op (0, 12..15): no register write, flags unchanged, set the sticky illegal bit, doneResult = 0.
    - Go to DONE.
  - DONE: doneValid = 1 for exactly this cycle. ALU outputs return to 0. Go to IDLE.
- ALU outputs are 0 in IDLE and DONE; they are non-zero only in EXEC.
- Latency: accept edge T; writeback at edge T+1; doneValid high during the cycle after T+1; instrReady high again the following cycle. Throughput is one operation per 3 cycles.
- Register 0 reads as 0 permanently; writes to it are discarded, but doneResult still reports aluResult.
- Source operands are sampled at the accept edge. Back-to-back dependent operations are always correct because there is no overlap.
- The illegal bit clears only on reset.
- instrWord is ignored while instrReady = 0. A held instrValid is accepted on the next IDLE cycle.
- Reset mid-operation: immediate return to IDLE. No doneValid, no writeback, and all state returns to its reset values.

Optional Feature:
Macro ALU_ISSUE_OPCOUNT_EN.
- Defined: adds output opCount (16 bits). It resets to 0 and increments at every EXEC closing edge, legal or illegal. It wraps from 0xFFFF to 0x0000.
- Undefined: the port and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then add rd=1, rsA=0, useImm, imm=5 -> EXEC drives aluFunction=1, A=0x00, B=0x05; r1=0x05; doneResult=0x05; doneValid one cycle; flags zero=0, carry=0.
- Subtract rd=2, rsA=0, imm=1, carry=0 -> r2=0xFF. Then add rd=3, rsA=2, imm=1 -> r3=0x00, zero=1, carry=1. Then subtract rd=4, rsA=0, imm=1 -> inputCarry=1 during EXEC; carry flag holds at 1.
- Op=0xE from IDLE -> no register change, illegal=1, doneResult=0. A following legal add still retires and illegal stays 1.
- Add rd=0, rsA=1, imm=3 with r1=5 -> doneResult=0x08; dbgAddr=0 reads 0x00.
- instrValid held high for 10 cycles with new words -> exactly 3 or 4 acceptances, spaced 3 cycles apart; instrReady=0 in EXEC and DONE.
- Assert reset during EXEC of add rd=5 -> no doneValid; r5=0; statusFlags=0; instrReady=1 the cycle after reset deasserts. With ALU_ISSUE_OPCOUNT_EN defined, opCount=0.
